// File: rtl/game_pkg.sv
// Shared board geometry, tile exponent codes and spawner state encoding.
package game_pkg;

  localparam int CELLS = 16;
  localparam int IDX_W = 4;
  localparam int VAL_W = 4;

  localparam logic [VAL_W-1:0] EXP_EMPTY = 4'd0;
  localparam logic [VAL_W-1:0] EXP_TWO   = 4'd1;
  localparam logic [VAL_W-1:0] EXP_FOUR  = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PROBE     = 3'd1,
    ST_SCAN      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_DONE_FULL = 3'd4
  } spawn_state_t;

endpackage

// File: rtl/tile_spawner_if.sv
// Request/board/random inputs and board-write/completion outputs of the spawner.
interface tile_spawner_if;
  import game_pkg::*;

  logic                   spawn_req;
  logic [CELLS*VAL_W-1:0] board_in;
  logic [IDX_W-1:0]       rand_idx;
  logic                   rand_two_or_four;
  logic                   busy;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;
  logic [VAL_W-1:0]       wr_val;
  logic                   spawn_done;
  logic                   board_full;

  // Requester side (game FSM plus random unit)
  modport master (
    output spawn_req, board_in, rand_idx, rand_two_or_four,
    input  busy, wr_en, wr_idx, wr_val, spawn_done, board_full
  );

  // Spawner side
  modport slave (
    input  spawn_req, board_in, rand_idx, rand_two_or_four,
    output busy, wr_en, wr_idx, wr_val, spawn_done, board_full
  );

endinterface

// File: rtl/cell_empty_mask.sv
// Flat board -> one bit per empty cell, plus a flag when no cell is empty.
module cell_empty_mask
  import game_pkg::*;
(
  input  logic [CELLS*VAL_W-1:0] board,
  output logic [CELLS-1:0]       empty_mask,
  output logic                   all_full
);

  // Per-cell zero detect
  always_comb begin
    empty_mask = '0;
    for (int i = 0; i < CELLS; i++) begin
      empty_mask[i] = (board[i*VAL_W +: VAL_W] == EXP_EMPTY);
    end
  end

  assign all_full = ~|empty_mask;

endmodule

// File: rtl/tile_spawner.sv
// Places one new tile on an empty cell: random probes first, then a linear
// scan once MAX_TRIES probes have missed.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for spawn_req; snapshots board and value flag
//   PROBE     | tests the cell at rand_idx each cycle, counts misses
//   SCAN      | walks scan_ptr (wrapping) until an empty cell is found
//   WRITE     | wr_en + spawn_done asserted for this one cycle
//   DONE_FULL | spawn_done + board_full asserted, no write
module tile_spawner
  import game_pkg::*;
#(
  parameter int MAX_TRIES = 8
) (
  input logic           clk,
  input logic           rst,
  tile_spawner_if.slave bus
);

  localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);

  spawn_state_t           state;
  logic [CELLS*VAL_W-1:0] snap_q;
  logic [3:0]             try_cnt;
  logic [IDX_W-1:0]       scan_ptr;
  logic                   flag_q;

  logic [CELLS*VAL_W-1:0] mask_src;
  logic [CELLS-1:0]       empty_mask;
  logic                   all_full;
  logic [IDX_W-1:0]       hit_idx;
  logic                   hit;

  // In IDLE the live board is the snapshot about to be taken, so the full
  // check at acceptance and the later probes share one mask instance.
  assign mask_src = (state == ST_IDLE) ? bus.board_in : snap_q;

  cell_empty_mask u_mask (
    .board      (mask_src),
    .empty_mask (empty_mask),
    .all_full   (all_full)
  );

  // Candidate cell for this cycle: random index while probing, pointer while scanning
  always_comb begin
    hit_idx = scan_ptr;
    if (state == ST_PROBE) begin
      hit_idx = bus.rand_idx;
    end
  end

  assign hit = empty_mask[hit_idx];

  // Spawner FSM with registered outputs; strobes default low each cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      snap_q         <= '0;
      try_cnt        <= '0;
      scan_ptr       <= '0;
      flag_q         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_idx     <= '0;
      bus.wr_val     <= '0;
      bus.spawn_done <= 1'b0;
      bus.board_full <= 1'b0;
    end else begin
      bus.wr_en      <= 1'b0;
      bus.spawn_done <= 1'b0;
      bus.board_full <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.spawn_req) begin
            snap_q   <= bus.board_in;
            try_cnt  <= '0;
            flag_q   <= bus.rand_two_or_four;
            bus.busy <= 1'b1;
            if (all_full) begin
              bus.spawn_done <= 1'b1;
              bus.board_full <= 1'b1;
              state          <= ST_DONE_FULL;
            end else begin
              state <= ST_PROBE;
            end
          end
        end
        ST_PROBE, ST_SCAN: begin
          if (hit) begin
            bus.wr_en      <= 1'b1;
            bus.spawn_done <= 1'b1;
            bus.wr_idx     <= hit_idx;
            bus.wr_val     <= flag_q ? EXP_TWO : EXP_FOUR;
            state          <= ST_WRITE;
          end else if (state == ST_PROBE) begin
            try_cnt <= try_cnt + 1'b1;
            if (try_cnt == TRY_LAST) begin
              scan_ptr <= bus.rand_idx + 1'b1;
              state    <= ST_SCAN;
            end
          end else begin
            scan_ptr <= scan_ptr + 1'b1;
          end
        end
        ST_WRITE, ST_DONE_FULL: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_spawner.sv
// Directed scoreboard bench for tile_spawner: stimulus pushes expected
// completions, a negedge monitor pops and compares them.
module tb_tile_spawner;

  typedef struct {
    logic       wr;
    logic [3:0] idx;
    logic [3:0] val;
    logic       full;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];

  tile_spawner_if bus ();

  tile_spawner #(.MAX_TRIES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done/write cycle must match the oldest expectation
  always @(negedge clk) begin
    if (bus.spawn_done === 1'b1 || bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: wr_en=%0d done=%0d with no request pending (cycle %0d)",
                 bus.wr_en, bus.spawn_done, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("spawn_done", int'(bus.spawn_done), 1);
        chk("wr_en", int'(bus.wr_en), int'(e.wr));
        chk("board_full", int'(bus.board_full), int'(e.full));
        chk("busy_at_done", int'(bus.busy), 1);
        chk("done_cycle", cyc, e.cyc);
        if (e.wr) begin
          chk("wr_idx", int'(bus.wr_idx), int'(e.idx));
          chk("wr_val", int'(bus.wr_val), int'(e.val));
        end
      end
    end
  end

  // Drive a request so it is sampled at the next edge N; lat is done-edge minus N
  task automatic issue(input logic [63:0] board, input logic flag, input logic [3:0] idx0,
                       input logic wr, input logic [3:0] idx, input logic [3:0] val,
                       input logic full, input int lat);
    exp_t e;
    @(negedge clk);
    bus.board_in         = board;
    bus.rand_two_or_four = flag;
    bus.rand_idx         = idx0;
    bus.spawn_req        = 1'b1;
    e.wr   = wr;
    e.idx  = idx;
    e.val  = val;
    e.full = full;
    e.cyc  = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    bus.spawn_req = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy !== 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: still busy after %0d cycles, %0d pending", limit, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    rst    = 1'b0;
    bus.spawn_req        = 1'b0;
    bus.board_in         = '0;
    bus.rand_idx         = '0;
    bus.rand_two_or_four = 1'b0;

    #2;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_done", int'(bus.spawn_done), 0);
    chk("rst_full", int'(bus.board_full), 0);
    chk("rst_wr_idx", int'(bus.wr_idx), 0);
    chk("rst_wr_val", int'(bus.wr_val), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Empty board, first probe hits; flag and board changed after acceptance
    issue(64'h0, 1'b1, 4'd5, 1'b1, 4'd5, 4'd1, 1'b0, 1);
    bus.rand_two_or_four = 1'b0;
    bus.board_in         = 64'h1111_1111_1111_1111;
    wait_idle(40);

    // Cell 3 occupied: probes 3, 3 miss, 9 hits
    issue(64'h0000_0000_0000_1000, 1'b0, 4'd3, 1'b1, 4'd9, 4'd2, 1'b0, 3);
    bus.rand_idx = 4'd3;
    @(negedge clk);
    bus.rand_idx = 4'd3;
    @(negedge clk);
    bus.rand_idx = 4'd9;
    wait_idle(40);

    // Only cell 0 empty, rand_idx stuck at 7: 8 misses, scan 8..15, wrap to 0
    issue(64'h1111_1111_1111_1110, 1'b1, 4'd7, 1'b1, 4'd0, 4'd1, 1'b0, 17);
    wait_idle(60);

    // Full board: done + full one cycle after acceptance, no write
    issue(64'h2121_2121_2121_2121, 1'b0, 4'd2, 1'b0, 4'd0, 4'd0, 1'b1, 0);
    wait_idle(40);
    chk("busy_after_full", int'(bus.busy), 0);

    // Requests while busy are dropped; one right after done is accepted
    issue(64'h0, 1'b0, 4'd12, 1'b1, 4'd12, 4'd2, 1'b0, 1);
    bus.spawn_req = 1'b1;
    @(negedge clk);
    issue(64'h0, 1'b1, 4'd4, 1'b1, 4'd4, 4'd1, 1'b0, 1);
    wait_idle(40);

    // Reset asserted mid-scan aborts without a write or done pulse
    @(negedge clk);
    bus.board_in         = 64'h1111_1111_1111_1110;
    bus.rand_two_or_four = 1'b1;
    bus.rand_idx         = 4'd7;
    bus.spawn_req        = 1'b1;
    @(negedge clk);
    bus.spawn_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_in_scan", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_done", int'(bus.spawn_done), 0);
    chk("abort_wr_idx", int'(bus.wr_idx), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Fresh request after the aborted one
    issue(64'h0, 1'b0, 4'd10, 1'b1, 4'd10, 4'd2, 1'b0, 1);
    wait_idle(40);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
